// File: rtl/edge_rate_meter.sv
// ---------------------------------------------------------------------------
// edge_rate_meter
//
// Counts rising edges on NUM_CH slow asynchronous test signals over a gate
// window of GATE_CYCLES clk cycles and publishes one saturating count per
// channel at the end of every window.
//
// Ports:
//   clk          system/reference clock (only clock)
//   rst          asynchronous active-low reset
//   en           run enable; windows run back-to-back while high
//   sig_in       asynchronous test signals, one bit per channel
//   counts       latched counts, channel i at [i*CNT_W +: CNT_W]
//   ovf          per-channel saturation flag of the latched window
//   counts_valid one-cycle strobe when counts/ovf update
//   busy         high while a window is in progress
//   state_dbg    FSM state for observation (0 = IDLE, 1 = GATE)
//
// Handshake: counts_valid is a push-only strobe with no ready. It is high for
// exactly one cycle, and counts/ovf hold their value from that cycle until the
// next strobe or a reset, so a consumer may sample them at any later time.
// ---------------------------------------------------------------------------
module edge_rate_meter #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         sig_in,
    output logic [NUM_CH*CNT_W-1:0]   counts,
    output logic [NUM_CH-1:0]         ovf,
    output logic                      counts_valid,
    output logic                      busy,
    output logic                      state_dbg
);

    localparam int              GW       = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]   LAST_CNT = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NUM_CH-1:0] s1_q, s1_d;
    logic [NUM_CH-1:0] s2_q, s2_d;
    logic [NUM_CH-1:0] s3_q, s3_d;
    logic [NUM_CH-1:0] rise;

    logic [NUM_CH-1:0][CNT_W-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0]            sat_q, sat_d;
    logic [GW-1:0]                gate_cnt_q, gate_cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] counts_q, counts_d;
    logic [NUM_CH-1:0]            ovf_q, ovf_d;
    logic                         valid_q, valid_d;

    logic [NUM_CH-1:0][CNT_W-1:0] sum;
    logic [NUM_CH-1:0]            lost;
    logic                         gate_last;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Leaving GATE on en low covers both the mid-window
    // abort and the normal end of the last window; the publish itself is
    // handled in the datapath and does not depend on en.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en)  state_d = S_GATE;
            S_GATE:  if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q == S_GATE);
        state_dbg = (state_q == S_GATE);
    end

    // ------------------------------------------------------------------
    // Synchronizer chain runs in every state so the first GATE cycle
    // already sees a settled edge detector.
    // ------------------------------------------------------------------
    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    assign rise = s2_q & ~s3_q;

    // Saturating add of this cycle's rise; lost marks an edge that could
    // not be counted because the accumulator was already at its ceiling.
    always_comb begin
        sum  = '0;
        lost = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lost[i] = rise[i] && (acc_q[i] == CNT_MAX);
            sum[i]  = lost[i] ? CNT_MAX : acc_q[i] + CNT_W'(rise[i]);
        end
    end

    // ------------------------------------------------------------------
    // Datapath next values. Accumulators, ovf tracking and gate counter
    // fall back to zero unless a window is running and continuing, which
    // covers IDLE, the window-end restart and the abort in one place.
    // ------------------------------------------------------------------
    always_comb begin
        gate_last  = (state_q == S_GATE) && (gate_cnt_q == LAST_CNT);
        acc_d      = '0;
        sat_d      = '0;
        gate_cnt_d = '0;
        counts_d   = counts_q;
        ovf_d      = ovf_q;
        valid_d    = gate_last;
        if (gate_last) begin
            // Last window cycle: its own rise still belongs to this window.
            counts_d = sum;
            ovf_d    = sat_q | lost;
        end else if ((state_q == S_GATE) && en) begin
            acc_d      = sum;
            sat_d      = sat_q | lost;
            gate_cnt_d = gate_cnt_q + GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            acc_q      <= '0;
            sat_q      <= '0;
            gate_cnt_q <= '0;
            counts_q   <= '0;
            ovf_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            gate_cnt_q <= gate_cnt_d;
            counts_q   <= counts_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign counts       = counts_q;
    assign ovf          = ovf_q;
    assign counts_valid = valid_q;

endmodule
